// File: rtl/sprite_rom_pkg.sv
// Shared widths, word types and pipeline stage record for the sprite ROM arbiter.
package sprite_rom_pkg;

    localparam int SPRITE_ADDR_W    = 11;
    localparam int SPRITE_DATA_W    = 3;
    localparam int SPRITE_ROM_DEPTH = 1600;
    // Wide enough for the largest supported requester count (8).
    localparam int SPRITE_ID_W      = 3;

    typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
    typedef logic [SPRITE_DATA_W-1:0] sprite_data_t;

    typedef struct packed {
        logic                   valid;
        logic [SPRITE_ID_W-1:0] id;
        logic                   err;
    } stage_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Round-robin grant logic with its own rotating priority pointer.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               sum;

    // Scan from the pointer upward, wrapping, and take the first valid request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = IDX_W'(sum);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Time-multiplexes one synchronous sprite ROM among NUM_REQ renderers with tagged responses.
// Optional bounds check on granted addresses: define SPRITE_ROM_ARB_BOUNDS_CHECK_EN.
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int ADDR_W    = SPRITE_ADDR_W,
    parameter  int DATA_W    = SPRITE_DATA_W,
    parameter  int ROM_DEPTH = SPRITE_ROM_DEPTH,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err
);

`ifdef SPRITE_ROM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
    logic [NUM_REQ-1:0]             grant;
    logic [ID_W-1:0]                gnt_idx;
    logic [ADDR_W-1:0]              gnt_addr;
    logic                           hs;
    logic                           oob;
    logic                           en_gated;
    stage_t                         s1;
    stage_t                         s2;

    // Reset holds the grant path off so nothing is offered while the pipeline is cleared.
    assign en_gated = en & reset_n;
    assign addr_arr = req_addr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .en    (en_gated),
        .req   (req_valid),
        .grant (grant),
        .idx   (gnt_idx)
    );

    assign req_ready = grant;
    assign hs        = |grant;
    assign gnt_addr  = addr_arr[gnt_idx];
    assign oob       = BOUNDS_CHECK && ({1'b0, gnt_addr} >= (ADDR_W+1)'(ROM_DEPTH));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            s1          <= '0;
            s2          <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            s1.valid <= hs;
            s1.id    <= SPRITE_ID_W'(gnt_idx);
            s1.err   <= hs & oob;
            // Out-of-range reads leave the ROM address alone; the response is squashed later.
            if (hs && !oob) rom_address <= gnt_addr;
            s2        <= s1;
            rsp_valid <= s2.valid;
            rsp_id    <= ID_W'(s2.id);
            rsp_data  <= s2.err ? '0 : rom_q;
            rsp_err   <= s2.err;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a queue-based response model and a toy ROM.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 3;

    logic                    vga_clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    en = 1'b1;
    logic [N-1:0]            req_valid = '1;
    logic [N-1:0][AW-1:0]    addr_arr = '0;
    logic [N-1:0]            req_ready;
    logic [AW-1:0]           rom_address;
    logic [DW-1:0]           rom_q = '0;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic [DW-1:0]           rsp_data;
    logic                    rsp_err;

    int vectors = 0;
    int miscompares = 0;

    sprite_rom_arbiter #(.NUM_REQ(N)) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_addr    (addr_arr),
        .req_ready   (req_ready),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        int t;
        t = int'(a) * 5 + 3;
        return DW'(t % 8);
    endfunction

    always @(posedge vga_clk) rom_q <= rom_word(rom_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int cyc;
        int id;
        int data;
        int err;
    } exp_t;

    exp_t    q[$];
    int      m_ptr = 0;
    int      cyc = 0;
    int      exp_addr = 0;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int r;
            r = (m_ptr + k) % N;
            if (en && req_valid[r]) return r;
        end
        return -1;
    endfunction

    function automatic bit out_of_range(input int a);
`ifdef SPRITE_ROM_ARB_BOUNDS_CHECK_EN
        return a >= 1600;
`else
        return (a < 0);
`endif
    endfunction

    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ptr = 0;
            exp_addr = 0;
            q.delete();
        end else begin
            int g;
            exp_t e;
            cyc++;
            g = model_grant();
            if (g >= 0) begin
                int a;
                a = int'(addr_arr[g]);
                e.cyc = cyc + 2;
                e.id  = g;
                if (out_of_range(a)) begin
                    e.data = 0;
                    e.err  = 1;
                end else begin
                    e.data = int'(rom_word(addr_arr[g]));
                    e.err  = 0;
                    exp_addr = a;
                end
                q.push_back(e);
                m_ptr = (g + 1) % N;
            end
        end
    end

    always @(negedge vga_clk) begin
        if (reset_n) begin
            int g;
            logic [N-1:0] exp_ready;
            g = model_grant();
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rom_address", 32'(rom_address), 32'(exp_addr));
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check("rsp_data", 32'(rsp_data), 32'(q[0].data));
                check("rsp_err", 32'(rsp_err), 32'(q[0].err));
                void'(q.pop_front());
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge vga_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [N-1:0] exp_oh;

        // Reset state with requests and en asserted.
        #2;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rom_address", 32'(rom_address), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        tick();
        req_valid = '0;
        reset_n = 1'b1;

        // Single requester 2, addr 0x05A, ROM word 5.
        tick();
        req_valid = 4'b0100;
        addr_arr[2] = 11'h05A;
        settle();
        check("s1_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        settle();
        check("s1_rsp_e0", 32'(rsp_valid), 32'd0);
        tick();
        settle();
        check("s1_rsp_e1", 32'(rsp_valid), 32'd0);
        tick();
        settle();
        check("s1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("s1_rsp_id", 32'(rsp_id), 32'd2);
        check("s1_rsp_data", 32'(rsp_data), 32'd5);
        tick();
        settle();
        check("s1_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // All four valid continuously from reset.
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N; i++) addr_arr[i] = AW'(16 * i + 7);
        req_valid = '1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            exp_oh = '0;
            exp_oh[k % N] = 1'b1;
            check("rr_order", 32'(req_ready), 32'(exp_oh));
            tick();
            addr_arr[k % N] = AW'(addr_arr[k % N] + 11'd100);
        end
        req_valid = '0;
        idle(3);

        // Pointer is now 1: grant 1 alone, moving it to 2, then contend 1 and 3.
        req_valid = 4'b0010;
        addr_arr[1] = 11'h123;
        tick();
        req_valid = 4'b1010;
        addr_arr[3] = 11'h3FF;
        settle();
        check("ptr2_first", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0010;
        settle();
        check("ptr2_second", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1111;
        settle();
        check("ptr_ends_2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        idle(3);

        // en dropped after two grants (3 then 0).
        req_valid = 4'b1111;
        en = 1'b1;
        tick();
        settle();
        tick();
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("en_off_ready", 32'(req_ready), 32'd0);
            if (rsp_valid) pulses++;
            tick();
        end
        check("en_off_pulses", 32'(pulses), 32'd2);
        en = 1'b1;
        settle();
        check("en_resume", 32'(req_ready), 32'b0010);

        // Reset while two reads are in flight.
        tick();
        settle();
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_ready", 32'(req_ready), 32'd0);
        check("arst_rom_address", 32'(rom_address), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_id", 32'(rsp_id), 32'd0);
        check("arst_rsp_data", 32'(rsp_data), 32'd0);
        check("arst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        tick();
        req_valid = '0;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        addr_arr[0] = 11'h00A;
        req_valid = 4'b1111;
        settle();
        check("post_reset_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        idle(3);

        // Address 1600 from requester 1.
        req_valid = 4'b0010;
        addr_arr[1] = 11'd1600;
        settle();
        check("oob_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        tick();
        settle();
        check("oob_rsp_valid", 32'(rsp_valid), 32'd1);
        check("oob_rsp_id", 32'(rsp_id), 32'd1);
`ifdef SPRITE_ROM_ARB_BOUNDS_CHECK_EN
        check("oob_rsp_err", 32'(rsp_err), 32'd1);
        check("oob_rsp_data", 32'(rsp_data), 32'd0);
        check("oob_rom_address", 32'(rom_address), 32'h00A);
`else
        check("oob_rsp_err", 32'(rsp_err), 32'd0);
        check("oob_rsp_data", 32'(rsp_data), 32'd3);
        check("oob_rom_address", 32'(rom_address), 32'd1600);
`endif
        tick();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
